digit_scan_counter: RTL

- Multi-digit up/down counter with a built-in display scanner. Sits directly upstream of the 4-bit-to-7-segment decoder.
- Counts at a prescaled tick rate and holds N_DIGITS digit values.
- Time-multiplexes the digits: presents one 4-bit digit on `dig` (to the decoder input) together with an active-low digit-enable vector `an` for the common-anode display.

---
 rtl/digit_scan_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/digit_scan_counter.sv
// Prescaled multi-digit up/down counter (BCD or hex) with a time-multiplexed digit scanner.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits during their scan slots.
module digit_scan_counter #(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int RADIX    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    output logic [3:0]            dig,
    output logic [N_DIGITS-1:0]   an,
    output logic [4*N_DIGITS-1:0] count,
    output logic                  wrap
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);
    localparam logic [3:0]    DIG_MAX  = 4'(RADIX - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [IW-1:0]         idx_nxt;
    logic                  tick;
    logic                  roll;
    logic                  scan_last;
    logic [4*N_DIGITS-1:0] count_nxt;
    logic [3:0]            cur;
    logic [3:0]            dig_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  blank;
`endif

    assign tick = en && (presc == TICK_MAX);

    // Ripple carry/borrow: roll stays set only if every digit wrapped.
    always_comb begin
        count_nxt = count;
        roll      = 1'b1;
        cur       = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            cur = count[4*i +: 4];
            if (roll) begin
                if (up) begin
                    if (cur == DIG_MAX) begin
                        count_nxt[4*i +: 4] = '0;
                    end else begin
                        count_nxt[4*i +: 4] = cur + 4'd1;
                        roll                = 1'b0;
                    end
                end else begin
                    if (cur == '0) begin
                        count_nxt[4*i +: 4] = DIG_MAX;
                    end else begin
                        count_nxt[4*i +: 4] = cur - 4'd1;
                        roll                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            presc <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                if (tick) begin
                    presc <= '0;
                    count <= count_nxt;
                    wrap  <= roll;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // dig/an are derived from the index they will hold next, so both register together.
    always_comb begin
        scan_last = (scan_cnt == SCAN_MAX);
        idx_nxt   = scan_idx;
        if (scan_last) begin
            idx_nxt = (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
        end
        dig_nxt = count[4*idx_nxt +: 4];
        an_nxt  = ~(N_DIGITS'(1) << idx_nxt);
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_nxt != '0);
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if ((i >= 32'(idx_nxt)) && (count[4*i +: 4] != '0)) begin
                blank = 1'b0;
            end
        end
        if (blank) begin
            an_nxt = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            dig      <= '0;
            an       <= ~(N_DIGITS'(1));
        end else begin
            scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
            scan_idx <= idx_nxt;
            dig      <= dig_nxt;
            an       <= an_nxt;
        end
    end

endmodule
